// File: rtl/vga_vram_arbiter.sv
// -----------------------------------------------------------------------------
// vga_vram_arbiter
//
// Shares one single-port synchronous VRAM between VGA scanout and a CPU-side
// req/ack requester. Scanout reads the 320x240 framebuffer at half resolution.
// Each framebuffer pixel is doubled in x and in y. Scanout has absolute
// priority: every even-x cycle inside the active area is a video slot. All
// other cycles (odd x and all blanking) are available to the CPU port.
//
// Ports
//   clock_25mhz      : pixel clock, only clock
//   reset_n          : synchronous active-low reset
//   x, y             : current pixel coordinates from vga_driver
//   hsync, vsync     : active-low syncs from vga_driver
//   in_active_area   : visible-area flag from vga_driver
//   pixel            : pixel value, 0 outside the active area
//   hsync_out,
//   vsync_out,
//   active_out       : timing inputs delayed 2 cycles, aligned with pixel
//   vram_addr        : VRAM address (combinational)
//   vram_we          : VRAM write enable (combinational)
//   vram_wdata       : VRAM write data (combinational)
//   vram_rdata       : VRAM read data, valid 1 cycle after the address
//   cpu_req          : CPU request, held with cpu_we/addr/wdata until cpu_ack
//   cpu_we           : 1 = write, 0 = read
//   cpu_addr         : linear framebuffer address
//   cpu_wdata        : CPU write data
//   cpu_rdata        : CPU read data, valid while cpu_ack is high
//   cpu_ack          : one-cycle completion pulse (grant + 2 cycles)
// -----------------------------------------------------------------------------
module vga_vram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240
) (
  input  logic                  clock_25mhz,
  input  logic                  reset_n,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  in_active_area,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  active_out,
  output logic [16:0]           vram_addr,
  output logic                  vram_we,
  output logic [DATA_WIDTH-1:0] vram_wdata,
  input  logic [DATA_WIDTH-1:0] vram_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [16:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack
);

  localparam logic [16:0] FB_SIZE = 17'(FB_WIDTH * FB_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } cpu_state_t;

  // Framebuffer address of a screen coordinate. Both coordinates are halved
  // because each framebuffer pixel covers a 2x2 block on screen. The default
  // 320-wide row is built from shifts and adds: 320 = 256 + 64.
  function automatic logic [16:0] fb_addr(input logic [9:0] sx, input logic [9:0] sy);
    logic [16:0] xa;
    logic [16:0] ya;
    xa = 17'(sx >> 1);
    ya = 17'(sy >> 1);
    if (FB_WIDTH == 320) begin
      fb_addr = (ya << 8) + (ya << 6) + xa;
    end else begin
      fb_addr = 17'(ya * 17'(FB_WIDTH)) + xa;
    end
  endfunction

  // Slot decode and CPU-side qualifiers
  logic        video_slot_s;
  logic [16:0] video_addr_s;
  logic        in_range_s;
  logic        grant_s;

  // FSM
  cpu_state_t  state_r;
  cpu_state_t  state_next_s;

  // Transaction attributes captured at grant, used in WAIT
  logic        txn_we_r;
  logic        txn_in_range_r;

  // Timing pipeline (2 stages) and pixel path
  logic        hsync_d1_r;
  logic        hsync_d2_r;
  logic        vsync_d1_r;
  logic        vsync_d2_r;
  logic        active_d1_r;
  logic        active_d2_r;
  logic        video_slot_d1_r;
  logic [DATA_WIDTH-1:0] pixel_r;
  logic [DATA_WIDTH-1:0] cpu_rdata_r;
  logic        cpu_ack_r;

  assign video_slot_s = in_active_area && (x[0] == 1'b0);
  assign video_addr_s = fb_addr(x, y);
  assign in_range_s   = (cpu_addr < FB_SIZE);

  // CPU FSM next-state logic; a grant only happens in IDLE on a CPU slot
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req && !video_slot_s) begin
          grant_s      = 1'b1;
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: state_next_s = ST_ACK;
      ST_ACK:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // VRAM port mux: video slot first, then CPU grant, otherwise an idle port
  always_comb begin
    vram_addr  = 17'd0;
    vram_we    = 1'b0;
    vram_wdata = {DATA_WIDTH{1'b0}};
    if (video_slot_s) begin
      vram_addr = video_addr_s;
    end else if (grant_s) begin
      vram_addr  = cpu_addr;
      vram_we    = cpu_we && in_range_s;
      vram_wdata = cpu_wdata;
    end else begin
      vram_addr  = 17'd0;
      vram_we    = 1'b0;
      vram_wdata = {DATA_WIDTH{1'b0}};
    end
  end

  // CPU FSM state register
  always_ff @(posedge clock_25mhz) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture read/write kind and range at grant; the requester holds its
  // inputs, but the captured copy keeps WAIT independent of that.
  always_ff @(posedge clock_25mhz) begin
    if (!reset_n) begin
      txn_we_r       <= 1'b0;
      txn_in_range_r <= 1'b0;
    end else if (grant_s) begin
      txn_we_r       <= cpu_we;
      txn_in_range_r <= in_range_s;
    end else begin
      txn_we_r       <= txn_we_r;
      txn_in_range_r <= txn_in_range_r;
    end
  end

  // Read data return: VRAM data arrives in WAIT; out-of-range reads return 0
  always_ff @(posedge clock_25mhz) begin
    if (!reset_n) begin
      cpu_rdata_r <= {DATA_WIDTH{1'b0}};
    end else if ((state_r == ST_WAIT) && !txn_we_r) begin
      cpu_rdata_r <= txn_in_range_r ? vram_rdata : {DATA_WIDTH{1'b0}};
    end else begin
      cpu_rdata_r <= cpu_rdata_r;
    end
  end

  // Ack flop: high exactly in the cycle the FSM sits in ACK
  always_ff @(posedge clock_25mhz) begin
    if (!reset_n) begin
      cpu_ack_r <= 1'b0;
    end else begin
      cpu_ack_r <= (state_next_s == ST_ACK);
    end
  end

  // Two-stage timing pipeline; reset values are the inactive levels
  always_ff @(posedge clock_25mhz) begin
    if (!reset_n) begin
      hsync_d1_r      <= 1'b1;
      hsync_d2_r      <= 1'b1;
      vsync_d1_r      <= 1'b1;
      vsync_d2_r      <= 1'b1;
      active_d1_r     <= 1'b0;
      active_d2_r     <= 1'b0;
      video_slot_d1_r <= 1'b0;
    end else begin
      hsync_d1_r      <= hsync;
      hsync_d2_r      <= hsync_d1_r;
      vsync_d1_r      <= vsync;
      vsync_d2_r      <= vsync_d1_r;
      active_d1_r     <= in_active_area;
      active_d2_r     <= active_d1_r;
      video_slot_d1_r <= video_slot_s;
    end
  end

  // Pixel register. active_d1_r becomes active_out on this same edge, so
  // clearing on it keeps pixel at 0 whenever active_out is 0. A video read
  // lands one cycle after its slot and is then held for the odd-x cycle.
  always_ff @(posedge clock_25mhz) begin
    if (!reset_n) begin
      pixel_r <= {DATA_WIDTH{1'b0}};
    end else if (!active_d1_r) begin
      pixel_r <= {DATA_WIDTH{1'b0}};
    end else if (video_slot_d1_r) begin
      pixel_r <= vram_rdata;
    end else begin
      pixel_r <= pixel_r;
    end
  end

  assign pixel      = pixel_r;
  assign hsync_out  = hsync_d2_r;
  assign vsync_out  = vsync_d2_r;
  assign active_out = active_d2_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign cpu_ack    = cpu_ack_r;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for vga_vram_arbiter. Drives a shortened VGA raster (208x8 visible),
// models a synchronous VRAM preloaded with mem[a] = a[7:0], and keeps a shadow
// copy of the framebuffer. For every driven cycle the expected
// {hsync_out, vsync_out, active_out, pixel} is pushed to a queue and popped
// two cycles later when the DUT shows it. CPU transactions are checked cycle
// by cycle against the expected grant/ack timeline.
// -----------------------------------------------------------------------------
module tb_vga_vram_arbiter;

  localparam int H_ACTIVE = 208;
  localparam int H_TOTAL  = 240;
  localparam int H_SS     = 216;
  localparam int H_SE     = 224;
  localparam int V_ACTIVE = 8;
  localparam int V_TOTAL  = 12;
  localparam int V_SS     = 9;
  localparam int V_SE     = 11;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam logic [10:0] RST_EXP = 11'h600;

  logic        clock_25mhz = 1'b0;
  logic        reset_n;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hsync;
  logic        vsync;
  logic        in_active_area;
  logic [7:0]  pixel;
  logic        hsync_out;
  logic        vsync_out;
  logic        active_out;
  logic [16:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  always #20 clock_25mhz = ~clock_25mhz;

  vga_vram_arbiter #(.DATA_WIDTH(8), .FB_WIDTH(320), .FB_HEIGHT(240)) dut (
    .clock_25mhz    (clock_25mhz),
    .reset_n        (reset_n),
    .x              (x),
    .y              (y),
    .hsync          (hsync),
    .vsync          (vsync),
    .in_active_area (in_active_area),
    .pixel          (pixel),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .active_out     (active_out),
    .vram_addr      (vram_addr),
    .vram_we        (vram_we),
    .vram_wdata     (vram_wdata),
    .vram_rdata     (vram_rdata),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ack        (cpu_ack)
  );

  // Synchronous single-port VRAM model, preloaded on the first edge
  logic [7:0] mem [0:131071];
  logic       mem_init_done = 1'b0;

  always @(posedge clock_25mhz) begin
    if (!mem_init_done) begin
      for (int a = 0; a < 131072; a++) mem[a] <= 8'(a);
      mem_init_done <= 1'b1;
    end else if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
    end
    vram_rdata <= mem[vram_addr];
  end

  logic [7:0]  shadow [0:76799];
  logic [10:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hcnt;
  int          vcnt;
  logic        rst_v, req_v, we_v;
  logic [16:0] addr_v;
  logic [7:0]  wd_v;
  logic        cur_slot;
  logic [16:0] cur_vaddr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One pixel cycle: drive inputs just after the edge, queue the expectation
  // for two cycles later, then compare the due entry at the falling edge.
  task automatic tick();
    logic hs, vs, act;
    logic [7:0] pix;
    @(posedge clock_25mhz);
    #1;
    hs  = !(hcnt >= H_SS && hcnt < H_SE);
    vs  = !(vcnt >= V_SS && vcnt < V_SE);
    act = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
    x = 10'(hcnt);
    y = 10'(vcnt);
    hsync = hs;
    vsync = vs;
    in_active_area = act;
    reset_n   = rst_v;
    cpu_req   = req_v;
    cpu_we    = we_v;
    cpu_addr  = addr_v;
    cpu_wdata = wd_v;
    cur_slot  = act && ((hcnt % 2) == 0);
    cur_vaddr = 17'((vcnt / 2) * 320 + hcnt / 2);
    pix = act ? shadow[cur_vaddr] : 8'h00;
    exp_q.push_back({hs, vs, act, pix});
    if (!rst_v) begin
      exp_q[1] = RST_EXP;
      exp_q[2] = RST_EXP;
    end
    hcnt++;
    if (hcnt == H_TOTAL) begin
      hcnt = 0;
      vcnt = (vcnt == V_TOTAL - 1) ? 0 : vcnt + 1;
    end
    @(negedge clock_25mhz);
    check("scan", 32'({hsync_out, vsync_out, active_out, pixel}), 32'(exp_q.pop_front()));
  endtask

  task automatic run_until(input int tx, input int ty);
    int n;
    n = 0;
    while (!(hcnt == tx && vcnt == ty) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check("reach", 32'((hcnt << 16) | vcnt), 32'((tx << 16) | ty));
  endtask

  task automatic cpu_txn(input string tag, input logic we, input logic [16:0] addr,
                         input logic [7:0] wd, input logic chk_rd, input logic [7:0] exp_rd,
                         input logic exp_we);
    int phase;
    phase  = 0;
    req_v  = 1'b1;
    we_v   = we;
    addr_v = addr;
    wd_v   = wd;
    for (int c = 0; c < 6 && phase < 3; c++) begin
      tick();
      if (phase == 0 && !cur_slot) begin
        check({tag, "_gaddr"}, 32'(vram_addr), 32'(addr));
        check({tag, "_gwe"}, 32'(vram_we), 32'(exp_we));
        check({tag, "_gwd"}, 32'(vram_wdata), 32'(wd));
        check({tag, "_gack"}, 32'(cpu_ack), 32'h0);
        phase = 1;
      end else begin
        check({tag, "_paddr"}, 32'(vram_addr), cur_slot ? 32'(cur_vaddr) : 32'h0);
        check({tag, "_pwe"}, 32'(vram_we), 32'h0);
        if (!cur_slot) check({tag, "_pwd"}, 32'(vram_wdata), 32'h0);
        if (phase == 2) begin
          check({tag, "_ack"}, 32'(cpu_ack), 32'h1);
          if (chk_rd) check({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp_rd));
          if (we && addr < 17'd76800) shadow[addr] = wd;
          req_v = 1'b0;
          phase = 3;
        end else begin
          check({tag, "_nack"}, 32'(cpu_ack), 32'h0);
          if (phase == 1) phase = 2;
        end
      end
    end
    check({tag, "_done"}, 32'(phase), 32'd3);
  endtask

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 76800; a++) shadow[a] = 8'(a);
    rst_v = 1'b0; req_v = 1'b0; we_v = 1'b0; addr_v = 17'd0; wd_v = 8'h00;
    reset_n = 1'b0; x = 10'd0; y = 10'd0; hsync = 1'b1; vsync = 1'b1;
    in_active_area = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 17'd0; cpu_wdata = 8'h00;
    repeat (3) @(posedge clock_25mhz);
    #1;
    exp_q.push_back(RST_EXP);
    exp_q.push_back(RST_EXP);
    rst_v = 1'b1;
    hcnt  = 0;
    vcnt  = V_TOTAL - 1;

    // Reset state of the CPU side
    tick();
    check("rst_ack", 32'(cpu_ack), 32'h0);
    check("rst_rdata", 32'(cpu_rdata), 32'h0);

    // Video address at (6,4) and the doubled pixel two and three cycles later
    run_until(6, 4);
    tick();
    check("vaddr_643", 32'(vram_addr), 32'd643);
    check("vwe_643", 32'(vram_we), 32'h0);
    tick();
    tick();
    check("pix_t2", 32'(pixel), 32'h83);
    tick();
    check("pix_t3", 32'(pixel), 32'h83);

    // Read raised on a video slot: deferred one cycle
    run_until(10, 4);
    cpu_txn("rd_vid", 1'b0, 17'd643, 8'h00, 1'b1, 8'h83, 1'b0);

    // Blanking: back-to-back writes, out-of-range traffic, read-back
    run_until(0, 9);
    cpu_txn("wr100", 1'b1, 17'd100, 8'h5A, 1'b0, 8'h00, 1'b1);
    cpu_txn("wr101", 1'b1, 17'd101, 8'hC3, 1'b0, 8'h00, 1'b1);
    cpu_txn("wr_oor", 1'b1, 17'd76800, 8'hA5, 1'b0, 8'h00, 1'b0);
    cpu_txn("rd_oor", 1'b0, 17'd131071, 8'h00, 1'b1, 8'h00, 1'b0);
    cpu_txn("rd101", 1'b0, 17'd101, 8'h00, 1'b1, 8'hC3, 1'b0);

    // Reset while in WAIT abandons the transaction
    req_v = 1'b1; we_v = 1'b1; addr_v = 17'd5000; wd_v = 8'h77;
    tick();
    check("rstw_gwe", 32'(vram_we), 32'h1);
    shadow[5000] = 8'h77;
    rst_v = 1'b0;
    req_v = 1'b0;
    tick();
    check("rstw_wait_ack", 32'(cpu_ack), 32'h0);
    rst_v = 1'b1;
    tick();
    check("rstw_ack", 32'(cpu_ack), 32'h0);
    check("rstw_rdata", 32'(cpu_rdata), 32'h0);
    check("rstw_pixel", 32'(pixel), 32'h0);
    tick();
    check("rstw_noack", 32'(cpu_ack), 32'h0);
    cpu_txn("post_rst", 1'b0, 17'd643, 8'h00, 1'b1, 8'h83, 1'b0);

    // Free-run two frames; the scoreboard covers the written pixels too
    for (int i = 0; i < 2 * FRAME; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
